// File: rtl/answer_checker.sv
// answer_checker: collects the player's answer one value per Go press,
// compares the full vector against the latched solver result and reports
// correct / wrong / locked, with limited retries and a timeout abort.
//
//  state | meaning
//  IDLE  | waiting for the solver's start pulse
//  ENTER | capturing one value per Go rising edge
//  CHECK | single cycle comparing the entered vector with the solution
//  PASS  | answer matched; correct held until re-armed
//  FAIL  | retries exhausted or timer expired; locked held until re-armed
module answer_checker #(
    parameter int WIDTH        = 8,
    parameter int NUM_VALUES   = 3,
    parameter int MAX_ATTEMPTS = 3
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        start,
    input  logic [NUM_VALUES*WIDTH-1:0] solution,
    input  logic [WIDTH-1:0]            user_in,
    input  logic                        Go,
    input  logic                        timeout,
    output logic                        busy,
    output logic [1:0]                  entry_idx,
    output logic [1:0]                  attempts_left,
    output logic                        correct,
    output logic                        wrong,
    output logic                        locked
);

    typedef enum logic [2:0] {IDLE, ENTER, CHECK, PASS, FAIL} state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_VALUES - 1);
    localparam logic [1:0] ATT_INIT = 2'(MAX_ATTEMPTS);

    state_t                      state, state_next;
    logic                        go_prev;
    logic                        go_rise;
    logic [NUM_VALUES*WIDTH-1:0] solution_q, solution_next;
    logic [NUM_VALUES*WIDTH-1:0] entry_q, entry_next;
    logic [1:0]                  entry_idx_next, attempts_next;
    logic                        correct_next, wrong_next, locked_next;

    // go_prev resets high so a button held through reset never looks like a press
    assign go_rise = Go & ~go_prev;
    assign busy    = (state == ENTER) || (state == CHECK);

    // state and datapath registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            go_prev       <= 1'b1;
            solution_q    <= '0;
            entry_q       <= '0;
            entry_idx     <= 2'd0;
            attempts_left <= ATT_INIT;
            correct       <= 1'b0;
            wrong         <= 1'b0;
            locked        <= 1'b0;
        end else begin
            state         <= state_next;
            go_prev       <= Go;
            solution_q    <= solution_next;
            entry_q       <= entry_next;
            entry_idx     <= entry_idx_next;
            attempts_left <= attempts_next;
            correct       <= correct_next;
            wrong         <= wrong_next;
            locked        <= locked_next;
        end
    end

    // next-state and register updates; timeout outranks Go and the compare result
    always_comb begin
        state_next     = state;
        solution_next  = solution_q;
        entry_next     = entry_q;
        entry_idx_next = entry_idx;
        attempts_next  = attempts_left;
        correct_next   = correct;
        wrong_next     = 1'b0;
        locked_next    = locked;

        case (state)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    solution_next  = solution;
                    entry_idx_next = 2'd0;
                    attempts_next  = ATT_INIT;
                    correct_next   = 1'b0;
                    locked_next    = 1'b0;
                    state_next     = ENTER;
                end
            end
            ENTER: begin
                if (timeout) begin
                    locked_next = 1'b1;
                    state_next  = FAIL;
                end else if (go_rise) begin
                    for (int i = 0; i < NUM_VALUES; i++) begin
                        if (entry_idx == 2'(i)) begin
                            entry_next[i*WIDTH +: WIDTH] = user_in;
                        end
                    end
                    if (entry_idx < LAST_IDX) begin
                        entry_idx_next = entry_idx + 2'd1;
                    end else begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (timeout) begin
                    locked_next = 1'b1;
                    state_next  = FAIL;
                end else if (entry_q == solution_q) begin
                    correct_next = 1'b1;
                    state_next   = PASS;
                end else if (attempts_left > 2'd1) begin
                    attempts_next  = attempts_left - 2'd1;
                    wrong_next     = 1'b1;
                    entry_idx_next = 2'd0;
                    state_next     = ENTER;
                end else begin
                    attempts_next = 2'd0;
                    wrong_next    = 1'b1;
                    locked_next   = 1'b1;
                    state_next    = FAIL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_answer_checker.sv
// Self-checking bench for answer_checker: directed scenarios plus randomized
// answer rounds predicted from the answer rules (vector equality, retry count).
module tb_answer_checker;

    localparam int W  = 8;
    localparam int NV = 3;
    localparam int MA = 3;

    logic            Clock = 1'b0;
    logic            Reset, start, Go, timeout;
    logic [NV*W-1:0] solution;
    logic [W-1:0]    user_in;
    logic            busy, correct, wrong, locked;
    logic [1:0]      entry_idx, attempts_left;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    answer_checker #(.WIDTH(W), .NUM_VALUES(NV), .MAX_ATTEMPTS(MA)) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .solution(solution),
        .user_in(user_in), .Go(Go), .timeout(timeout), .busy(busy),
        .entry_idx(entry_idx), .attempts_left(attempts_left),
        .correct(correct), .wrong(wrong), .locked(locked)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [NV*W-1:0] pack(input int v [NV]);
        logic [NV*W-1:0] p;
        p = '0;
        for (int i = 0; i < NV; i++) p[i*W +: W] = W'(v[i]);
        return p;
    endfunction

    function automatic bit same(input int a [NV], input int b [NV]);
        for (int i = 0; i < NV; i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic rand_vec(output int v [NV]);
        for (int i = 0; i < NV; i++) v[i] = int'($urandom_range(0, 255));
    endtask

    task automatic arm(input int v [NV]);
        solution = pack(v);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic press(input int val);
        user_in = W'(val);
        Go      = 1'b1;
        tick();
        Go      = 1'b0;
        tick();
    endtask

    // Enters a whole vector; returns outputs during the compare cycle and after it.
    task automatic submit(input int v [NV], output logic chk_busy, output logic chk_correct,
                          output logic chk_wrong, output logic res_correct, output logic res_wrong,
                          output logic res_locked, output logic res_busy,
                          output logic [1:0] res_att, output logic [1:0] res_idx);
        for (int i = 0; i < NV - 1; i++) press(v[i]);
        user_in = W'(v[NV-1]);
        Go      = 1'b1;
        tick();
        Go          = 1'b0;
        chk_busy    = busy;
        chk_correct = correct;
        chk_wrong   = wrong;
        tick();
        res_correct = correct;
        res_wrong   = wrong;
        res_locked  = locked;
        res_busy    = busy;
        res_att     = attempts_left;
        res_idx     = entry_idx;
    endtask

    task automatic test_reset();
        int v [NV];
        Reset = 1'b1; Go = 1'b1; start = 1'b0; timeout = 1'b0; user_in = '0; solution = '0;
        tick(); tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b need 0", busy); end
        tests_run++; if (entry_idx !== 2'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d need 0", entry_idx); end
        tests_run++; if (attempts_left !== 2'(MA)) begin tests_failed++; $display("FAIL reset_att: got %0d need %0d", attempts_left, MA); end
        tests_run++; if (correct !== 1'b0) begin tests_failed++; $display("FAIL reset_correct: got %0b need 0", correct); end
        tests_run++; if (wrong !== 1'b0) begin tests_failed++; $display("FAIL reset_wrong: got %0b need 0", wrong); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %0b need 0", locked); end
        Reset = 1'b0;
        v = '{2, 3, 1};
        arm(v);
        tick();
        tests_run++; if (entry_idx !== 2'd0) begin tests_failed++; $display("FAIL held_go_idx: got %0d need 0", entry_idx); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL held_go_busy: got %0b need 1", busy); end
        Go = 1'b0;
        tick();
    endtask

    task automatic test_correct();
        int v [NV];
        logic cb, cc, cw, rc, rw, rl, rb;
        logic [1:0] ra, ri;
        press(2);
        tests_run++; if (entry_idx !== 2'd1) begin tests_failed++; $display("FAIL idx_after_1: got %0d need 1", entry_idx); end
        press(3);
        tests_run++; if (entry_idx !== 2'd2) begin tests_failed++; $display("FAIL idx_after_2: got %0d need 2", entry_idx); end
        user_in = 8'd1; Go = 1'b1;
        tick();
        Go = 1'b0;
        tests_run++; if (correct !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL check_cycle: got correct=%0b busy=%0b need 0/1", correct, busy); end
        tick();
        tests_run++; if (correct !== 1'b1 || wrong !== 1'b0) begin tests_failed++; $display("FAIL pass_231: got correct=%0b wrong=%0b need 1/0", correct, wrong); end
        tests_run++; if (attempts_left !== 2'(MA) || busy !== 1'b0) begin tests_failed++; $display("FAIL pass_231_att: got att=%0d busy=%0b need %0d/0", attempts_left, busy, MA); end
        tick(); tick();
        tests_run++; if (correct !== 1'b1) begin tests_failed++; $display("FAIL correct_held: got %0b need 1", correct); end
        rand_vec(v);
        arm(v);
        tests_run++; if (correct !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL rearm_pass: got correct=%0b busy=%0b need 0/1", correct, busy); end
        submit(v, cb, cc, cw, rc, rw, rl, rb, ra, ri);
        tests_run++; if (rc !== 1'b1 || rw !== 1'b0 || cw !== 1'b0) begin tests_failed++; $display("FAIL pass_random: got correct=%0b wrong=%0b/%0b need 1 0/0", rc, rw, cw); end
    endtask

    task automatic test_retry();
        int v [NV];
        int bad [NV];
        int k;
        logic cb, cc, cw, rc, rw, rl, rb;
        logic [1:0] ra, ri;
        rand_vec(v);
        bad = v;
        k = int'($urandom_range(0, NV - 1));
        bad[k] = (v[k] + int'($urandom_range(1, 255))) % 256;
        arm(v);
        submit(bad, cb, cc, cw, rc, rw, rl, rb, ra, ri);
        tests_run++; if (rw !== 1'b1 || rc !== 1'b0) begin tests_failed++; $display("FAIL retry_wrong: got wrong=%0b correct=%0b need 1/0", rw, rc); end
        tests_run++; if (ra !== 2'(MA - 1) || ri !== 2'd0 || rb !== 1'b1) begin tests_failed++; $display("FAIL retry_state: got att=%0d idx=%0d busy=%0b need %0d 0 1", ra, ri, rb, MA - 1); end
        tick();
        tests_run++; if (wrong !== 1'b0) begin tests_failed++; $display("FAIL wrong_one_cycle: got %0b need 0", wrong); end
        submit(v, cb, cc, cw, rc, rw, rl, rb, ra, ri);
        tests_run++; if (rc !== 1'b1 || rw !== 1'b0 || ra !== 2'(MA - 1)) begin tests_failed++; $display("FAIL retry_pass: got correct=%0b wrong=%0b att=%0d need 1 0 %0d", rc, rw, ra, MA - 1); end
    endtask

    task automatic test_lockout();
        int v [NV];
        int z [NV];
        logic cb, cc, cw, rc, rw, rl, rb;
        logic [1:0] ra, ri;
        rand_vec(v);
        v[0] = int'($urandom_range(1, 255));
        z = '{0, 0, 0};
        arm(v);
        for (int a = 1; a <= MA; a++) begin
            submit(z, cb, cc, cw, rc, rw, rl, rb, ra, ri);
            tests_run++;
            if (rw !== 1'b1 || ra !== 2'(MA - a) || rl !== (a == MA) || rb !== (a < MA)) begin
                tests_failed++;
                $display("FAIL lockout_%0d: got wrong=%0b att=%0d locked=%0b busy=%0b need 1 %0d %0b %0b", a, rw, ra, rl, rb, MA - a, a == MA, a < MA);
            end
        end
        for (int i = 0; i < NV; i++) press(v[i]);
        tests_run++; if (locked !== 1'b1 || correct !== 1'b0 || attempts_left !== 2'd0 || wrong !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL locked_go_ignored: got locked=%0b correct=%0b att=%0d wrong=%0b busy=%0b need 1 0 0 0 0", locked, correct, attempts_left, wrong, busy);
        end
    endtask

    task automatic test_timeout();
        int v [NV];
        logic cb, cc, cw, rc, rw, rl, rb;
        logic [1:0] ra, ri;
        rand_vec(v);
        arm(v);
        press(v[0]);
        user_in = W'(v[1]); Go = 1'b1; timeout = 1'b1;
        tick();
        Go = 1'b0; timeout = 1'b0;
        tests_run++; if (locked !== 1'b1 || wrong !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_enter: got locked=%0b wrong=%0b busy=%0b need 1 0 0", locked, wrong, busy); end
        tests_run++; if (attempts_left !== 2'(MA) || entry_idx !== 2'd1) begin tests_failed++; $display("FAIL timeout_no_capture: got att=%0d idx=%0d need %0d 1", attempts_left, entry_idx, MA); end
        tick();
        tests_run++; if (wrong !== 1'b0 || locked !== 1'b1) begin tests_failed++; $display("FAIL timeout_after: got wrong=%0b locked=%0b need 0 1", wrong, locked); end
        rand_vec(v);
        arm(v);
        tests_run++; if (locked !== 1'b0 || busy !== 1'b1 || entry_idx !== 2'd0 || attempts_left !== 2'(MA)) begin
            tests_failed++; $display("FAIL rearm_fail: got locked=%0b busy=%0b idx=%0d att=%0d need 0 1 0 %0d", locked, busy, entry_idx, attempts_left, MA);
        end
        press(v[0]); press(v[1]);
        user_in = W'(v[2]); Go = 1'b1;
        tick();
        Go = 1'b0; timeout = 1'b1;
        tick();
        timeout = 1'b0;
        tests_run++; if (correct !== 1'b0 || locked !== 1'b1 || wrong !== 1'b0 || attempts_left !== 2'(MA)) begin
            tests_failed++; $display("FAIL timeout_check: got correct=%0b locked=%0b wrong=%0b att=%0d need 0 1 0 %0d", correct, locked, wrong, attempts_left, MA);
        end
        arm(v);
        submit(v, cb, cc, cw, rc, rw, rl, rb, ra, ri);
        tests_run++; if (rc !== 1'b1 || rl !== 1'b0) begin tests_failed++; $display("FAIL after_timeout_pass: got correct=%0b locked=%0b need 1 0", rc, rl); end
    endtask

    task automatic test_start_ignored();
        int v [NV];
        int w [NV];
        rand_vec(v);
        w = v;
        w[0] = v[0] ^ 1;
        arm(v);
        press(v[0]);
        solution = pack(w); start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++; if (entry_idx !== 2'd1 || busy !== 1'b1) begin tests_failed++; $display("FAIL start_ignored_idx: got idx=%0d busy=%0b need 1 1", entry_idx, busy); end
        press(v[1]);
        press(v[2]);
        tests_run++; if (correct !== 1'b1 || wrong !== 1'b0) begin tests_failed++; $display("FAIL start_no_relatch: got correct=%0b wrong=%0b need 1 0", correct, wrong); end
    endtask

    task automatic test_reset_mid();
        int v [NV];
        rand_vec(v);
        arm(v);
        press(v[0]); press(v[1]);
        tests_run++; if (entry_idx !== 2'd2) begin tests_failed++; $display("FAIL mid_idx: got %0d need 2", entry_idx); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests_run++; if (busy !== 1'b0 || entry_idx !== 2'd0 || attempts_left !== 2'(MA) || correct !== 1'b0 || wrong !== 1'b0 || locked !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset: got busy=%0b idx=%0d att=%0d c=%0b w=%0b l=%0b need 0 0 %0d 0 0 0", busy, entry_idx, attempts_left, correct, wrong, locked, MA);
        end
        press(v[2]);
        tests_run++; if (busy !== 1'b0 || entry_idx !== 2'd0) begin tests_failed++; $display("FAIL idle_go_ignored: got busy=%0b idx=%0d need 0 0", busy, entry_idx); end
    endtask

    task automatic test_random();
        int v [NV];
        int t [NV];
        int m_att;
        int k;
        bit done;
        bit match;
        logic cb, cc, cw, rc, rw, rl, rb;
        logic [1:0] ra, ri;
        for (int r = 0; r < 15; r++) begin
            rand_vec(v);
            arm(v);
            tests_run++; if (correct !== 1'b0 || locked !== 1'b0 || attempts_left !== 2'(MA) || entry_idx !== 2'd0) begin
                tests_failed++; $display("FAIL rnd_arm_%0d: got c=%0b l=%0b att=%0d idx=%0d need 0 0 %0d 0", r, correct, locked, attempts_left, entry_idx, MA);
            end
            m_att = MA;
            done  = 1'b0;
            while (!done) begin
                case ($urandom_range(0, 2))
                    0: t = v;
                    1: begin t = v; k = int'($urandom_range(0, NV - 1)); t[k] = (v[k] + int'($urandom_range(1, 255))) % 256; end
                    default: begin
                        for (int i = 0; i < NV; i++) t[i] = ($urandom_range(0, 1) == 0) ? v[i] : int'($urandom_range(0, 255));
                    end
                endcase
                match = same(t, v);
                submit(t, cb, cc, cw, rc, rw, rl, rb, ra, ri);
                if (!match) m_att--;
                tests_run++;
                if (cb !== 1'b1 || cc !== 1'b0 || cw !== 1'b0 || rc !== match || rw !== !match || ra !== 2'(m_att) ||
                    rl !== (!match && m_att == 0) || rb !== (!match && m_att > 0)) begin
                    tests_failed++;
                    $display("FAIL rnd_%0d: got chk=%0b%0b%0b c=%0b w=%0b att=%0d l=%0b b=%0b need 100 %0b %0b %0d %0b %0b",
                             r, cb, cc, cw, rc, rw, ra, rl, rb, match, !match, m_att, !match && m_att == 0, !match && m_att > 0);
                end
                done = match || (m_att == 0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_retry();
        test_lockout();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/answer_checker.md
Name: answer_checker

Overview:
- Downstream consumer of the equation solver stages: takes the solver's final solution vector and collects the player's answer, one value per Go press, from the board switches.
- Compares the full entered vector with the solution and decides pass or fail, with limited retries and a timer-expiry abort.
- Its correct/wrong outputs drive the alarm-dismiss logic and the display.

Parameters:
- WIDTH, 8, bit width of each solution value and of the switch input.
- NUM_VALUES, 3, number of values per answer (x, y, z).
- MAX_ATTEMPTS, 3, full-vector submissions allowed before lockout (1..3).

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse from the solver when its solution is valid; arms the checker.
- solution  input  NUM_VALUES*WIDTH  solver result; value 0 in bits [WIDTH-1:0], value i in bits [(i+1)*WIDTH-1 : i*WIDTH].
- user_in  input  WIDTH  switch value presented by the player.
- Go  input  1  entry button, active-high level, already synchronised; only its rising edge is used.
- timeout  input  1  level from the ongoing timer; high means time has expired.
- busy  output  1  high while an answer is being collected or checked.
- entry_idx  output  2  index of the value the next Go press captures.
- attempts_left  output  2  remaining submissions.
- correct  output  1  high (held) once the answer matches.
- wrong  output  1  one-cycle pulse on each mismatching submission.
- locked  output  1  high (held) after the final failure or a timeout.

Behaviour:
- Reset values: state IDLE, busy=0, entry_idx=0, attempts_left=MAX_ATTEMPTS, correct=0, wrong=0, locked=0, go_prev=1, all latched solution and entry registers 0.
- go_prev resets to 1 so a button held through reset never produces an edge.
- Go edge: go_rise = Go & ~go_prev; go_prev<=Go on every clock in every state.
- States: IDLE, ENTER, CHECK, PASS, FAIL.
- IDLE:
  - On start=1: latch solution, set entry_idx=0, attempts_left=MAX_ATTEMPTS, clear correct/locked, go to ENTER.
  - go_rise is ignored.
- ENTER (busy=1):
  - On go_rise: store user_in into entry[entry_idx] at that edge.
  - If entry_idx<NUM_VALUES-1, increment entry_idx.
  - Otherwise go to CHECK; entry_idx stays at NUM_VALUES-1.
- CHECK (busy=1, exactly one cycle):
  - Compare all NUM_VALUES entries with the latched solution, bitwise and unsigned.
  - On match: go to PASS; correct=1 from the next edge.
  - On mismatch with attempts_left>1: decrement attempts_left, pulse wrong for one cycle, clear entry_idx to 0, return to ENTER.
  - On mismatch with attempts_left==1: set attempts_left=0, pulse wrong, set locked=1, go to FAIL.
- Latency: correct or wrong is visible in the 2nd cycle after the clock edge that captured the last value.
- PASS and FAIL:
  - busy=0; correct and locked are held.
  - start re-arms exactly as in IDLE, clearing correct and locked.
  - Go and timeout are ignored.
- timeout=1 while in ENTER or CHECK: go to FAIL at that edge, locked=1, wrong is not pulsed, attempts_left is unchanged.
  - timeout has priority over go_rise and over the CHECK result on the same edge.
- start while in ENTER or CHECK is ignored: no re-latch, progress is kept.
- A mid-operation Reset returns everything to the reset values at the next edge.
- Entries are not cleared between attempts; each Go overwrites its slot.

Test Plan:
- Reset with Go held high, release Go, then start with solution=(2,3,1) -> no capture occurs; entry_idx=0, busy=1.
- Enter 2,3,1 with one Go rising edge each -> correct=1 two cycles after the third capture edge; wrong never pulses; attempts_left=3.
- Enter 2,3,4, then 2,3,1 -> one wrong pulse and attempts_left=2 after the first vector; correct=1 after the second.
- Three wrong vectors (0,0,0) with MAX_ATTEMPTS=3 -> wrong pulses three times, attempts_left ends at 0, locked=1, state FAIL; a further Go has no effect.
- After one entry, raise timeout on the same cycle as a Go rising edge -> locked=1, no capture, no wrong pulse; a subsequent start re-arms with locked=0.
- Assert Reset during ENTER with entry_idx=2 -> at the next edge all outputs equal their reset values and the state is IDLE.
